// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared state encoding and default geometry for int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    localparam int c_pc_w       = 10;
    localparam int c_vec_base   = 'h3E0;
    localparam int c_vec_stride = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/int_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchroniser for one request line plus rise detect.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // One-cycle pulse on the first synchronised high sample.
    assign rise = r_s2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Non-nesting vectored interrupt controller driving PC mux/stack.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int              NIRQ       = 4,
    parameter int              PC_W       = c_pc_w,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(c_vec_base),
    parameter int              VEC_STRIDE = c_vec_stride
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_d,
    input  logic            ei,
    input  logic            di,
    input  logic            reti,
    input  logic            instr_boundary,
    input  logic [PC_W-1:0] pc_next,
    output logic            take_int,
    output logic [PC_W-1:0] vector,
    output logic            push,
    output logic [PC_W-1:0] push_data,
    output logic            pop,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] in_service,
    output logic            gie
);

    localparam int c_idx_w = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NIRQ-1:0]   r_mask;
    logic [NIRQ-1:0]   r_pending;
    logic [NIRQ-1:0]   r_in_service;
    logic              r_gie;
    logic [NIRQ-1:0]   w_rise;
    logic [NIRQ-1:0]   w_eligible;
    logic [NIRQ-1:0]   w_win_onehot;
    logic [NIRQ-1:0]   w_clr;
    logic [c_idx_w-1:0] w_win_idx;
    logic [PC_W-1:0]   w_vec;
    logic              w_take;
    logic              w_pop;

    for (genvar gi = 0; gi < NIRQ; gi++) begin : g_sync
        sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (irq_in[gi]),
            .rise  (w_rise[gi])
        );
    end

    assign w_eligible = r_pending & r_mask;

    // Scan downwards so the lowest set index is the last write and wins.
    always_comb begin
        w_win_idx    = '0;
        w_win_onehot = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_idx       = c_idx_w'(i);
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    assign w_vec = VEC_BASE + (PC_W'(w_win_idx) * PC_W'(VEC_STRIDE));

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_gie && (|w_eligible) && instr_boundary && !di) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_ISR;
                end
            end
            ST_ISR: begin
                if (reti) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_clr = w_take ? w_win_onehot : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mask       <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_gie        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (mask_we) begin
                r_mask <= mask_d;
            end
            // A new edge on the line being cleared keeps it pending.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_take) begin
                r_in_service <= w_win_onehot;
            end else if (w_pop) begin
                r_in_service <= '0;
            end
            if (w_take) begin
                r_gie <= 1'b0;
            end else if (w_pop) begin
                r_gie <= 1'b1;
            end else if (di) begin
                r_gie <= 1'b0;
            end else if (ei) begin
                r_gie <= 1'b1;
            end
        end
    end

    assign take_int   = w_take;
    assign push       = w_take;
    assign vector     = w_take ? w_vec : '0;
    assign push_data  = w_take ? pc_next : '0;
    assign pop        = w_pop;
    assign pending    = r_pending;
    assign in_service = r_in_service;
    assign gie        = r_gie;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Directed cycle-table bench for int_ctrl with reset corner case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_d;
    logic       ei, di, reti, instr_boundary;
    logic [9:0] pc_next;
    logic       take_int, push, pop, gie;
    logic [9:0] vector, push_data;
    logic [3:0] pending, in_service;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] irq;
        logic       mwe;
        logic [3:0] md;
        logic       ei;
        logic       di;
        logic       reti;
        logic       ib;
        logic [9:0] pc;
        logic       take;
        logic [9:0] vec;
        logic       pop;
        logic [3:0] pend;
        logic [3:0] insv;
        logic       gie;
    } row_t;

    row_t rows[$];

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .irq_in         (irq_in),
        .mask_we        (mask_we),
        .mask_d         (mask_d),
        .ei             (ei),
        .di             (di),
        .reti           (reti),
        .instr_boundary (instr_boundary),
        .pc_next        (pc_next),
        .take_int       (take_int),
        .vector         (vector),
        .push           (push),
        .push_data      (push_data),
        .pop            (pop),
        .pending        (pending),
        .in_service     (in_service),
        .gie            (gie)
    );

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] irq, input logic mwe, input logic [3:0] md,
                       input logic e, input logic d, input logic r, input logic ib,
                       input logic [9:0] pc, input logic tk, input logic [9:0] vc,
                       input logic pp, input logic [3:0] pd, input logic [3:0] is,
                       input logic g);
        row_t x;
        x = '{irq, mwe, md, e, d, r, ib, pc, tk, vc, pp, pd, is, g};
        rows.push_back(x);
    endtask

    task automatic check_all(input int idx, input logic tk, input logic [9:0] vc,
                             input logic [9:0] pdata, input logic pp,
                             input logic [3:0] pd, input logic [3:0] is, input logic g);
        chk("take_int",   idx, 16'(take_int),   16'(tk));
        chk("push",       idx, 16'(push),       16'(tk));
        chk("vector",     idx, 16'(vector),     16'(vc));
        chk("push_data",  idx, 16'(push_data),  16'(pdata));
        chk("pop",        idx, 16'(pop),        16'(pp));
        chk("pending",    idx, 16'(pending),    16'(pd));
        chk("in_service", idx, 16'(in_service), 16'(is));
        chk("gie",        idx, 16'(gie),        16'(g));
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; mask_we = 0; mask_d = '0;
        ei = 0; di = 0; reti = 0; instr_boundary = 0; pc_next = '0;

        //   irq  we md   ei di rt ib pc       take vec     pop pend insv gie
        add(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 0); // 0 reset state
        add(4'h0, 1, 4'hF, 1, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 0); // 1 ei, mask=F
        add(4'h4, 0, 4'h0, 0, 0, 0, 1, 10'h045, 0, 10'h000, 0, 4'h0, 4'h0, 1); // 2 irq2 pulse
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h045, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h045, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h045, 1, 10'h3E8, 0, 4'h4, 4'h0, 1); // 5 take line 2
        add(4'h1, 0, 4'h0, 1, 0, 0, 1, 10'h046, 0, 10'h000, 0, 4'h0, 4'h4, 0); // 6 ISR, irq0, ei
        add(4'h1, 0, 4'h0, 0, 0, 0, 1, 10'h046, 0, 10'h000, 0, 4'h0, 4'h4, 1);
        add(4'h1, 0, 4'h0, 0, 0, 0, 1, 10'h046, 0, 10'h000, 0, 4'h0, 4'h4, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h047, 0, 10'h000, 0, 4'h1, 4'h4, 1); // 9 held, no nest
        add(4'h0, 0, 4'h0, 0, 0, 1, 1, 10'h050, 0, 10'h000, 1, 4'h1, 4'h4, 1); // 10 reti
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h050, 1, 10'h3E0, 0, 4'h1, 4'h0, 1); // 11 take line 0
        add(4'h0, 0, 4'h0, 0, 0, 1, 0, 10'h000, 0, 10'h000, 1, 4'h0, 4'h1, 0);
        add(4'hA, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1); // 13 irq3+irq1
        add(4'hA, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h060, 1, 10'h3E4, 0, 4'hA, 4'h0, 1); // 16 line 1 first
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h061, 0, 10'h000, 0, 4'h8, 4'h2, 0);
        add(4'h0, 0, 4'h0, 0, 0, 1, 1, 10'h062, 0, 10'h000, 1, 4'h8, 4'h2, 0);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h062, 1, 10'h3EC, 0, 4'h8, 4'h0, 1); // 19 line 3
        add(4'h0, 0, 4'h0, 0, 0, 1, 0, 10'h000, 0, 10'h000, 1, 4'h0, 4'h8, 0);
        add(4'h2, 1, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1); // 21 mask=0, irq1
        add(4'h2, 0, 4'h0, 0, 0, 0, 1, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h070, 0, 10'h000, 0, 4'h2, 4'h0, 1); // 24 masked, held
        add(4'h0, 1, 4'h2, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h2, 4'h0, 1); // 25 mask=0010
        add(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h2, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h071, 1, 10'h3E4, 0, 4'h2, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0, 10'h000, 0, 10'h000, 1, 4'h0, 4'h2, 0);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1); // 29 reti in IDLE
        add(4'h0, 0, 4'h0, 1, 1, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1); // 30 ei+di
        add(4'h0, 0, 4'h0, 1, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 0);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h1, 1, 4'hF, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1); // 33 irq0, mask=F
        add(4'h1, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h0, 1);
        add(4'h0, 0, 4'h0, 0, 1, 0, 1, 10'h080, 0, 10'h000, 0, 4'h1, 4'h0, 1); // 36 di blocks take
        add(4'h0, 0, 4'h0, 1, 0, 0, 1, 10'h080, 0, 10'h000, 0, 4'h1, 4'h0, 0);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1, 10'h081, 1, 10'h3E0, 0, 4'h1, 4'h0, 1);
        add(4'hA, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h1, 0); // 39 ISR, irq3+1
        add(4'hA, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h1, 0);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'h0, 4'h1, 0);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 4'hA, 4'h1, 0); // 42 pending=1010

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < rows.size(); i++) begin
            if (i > 0) @(negedge clk);
            irq_in = rows[i].irq; mask_we = rows[i].mwe; mask_d = rows[i].md;
            ei = rows[i].ei; di = rows[i].di; reti = rows[i].reti;
            instr_boundary = rows[i].ib; pc_next = rows[i].pc;
            #2;
            check_all(i, rows[i].take, rows[i].vec, rows[i].take ? rows[i].pc : 10'h000,
                      rows[i].pop, rows[i].pend, rows[i].insv, rows[i].gie);
        end

        // Asynchronous reset while in ISR with lines 1 and 3 pending.
        reti = 1'b1;
        #1;
        chk("pop_before_reset", 100, 16'(pop), 16'd1);
        reset = 1'b1;
        #1;
        check_all(101, 0, 10'h000, 10'h000, 0, 4'h0, 4'h0, 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_all(102, 0, 10'h000, 10'h000, 0, 4'h0, 4'h0, 0);
        @(negedge clk);
        #2;
        check_all(103, 0, 10'h000, 10'h000, 0, 4'h0, 4'h0, 0);
        reti = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Vectored interrupt controller that sits directly upstream of the PC-select mux and the return-address stack (`pila`). It synchronises external request lines, latches them as pending, and arbitrates by fixed priority. At an instruction boundary it diverts the PC to a vector address and pushes the resume address onto the stack. On return-from-interrupt it issues the stack pop. Nesting is not supported: one interrupt is in service at a time.

Parameters:
NIRQ, 4, number of interrupt request lines (1..8)
PC_W, 10, program-counter width; must match the stack and PC register
VEC_BASE, 10'h3E0, address of the vector for line 0
VEC_STRIDE, 4, address distance between consecutive vectors

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
irq_in  in  NIRQ  raw external requests, asynchronous, rising-edge sensitive
mask_we  in  1  write strobe for per-line enable mask
mask_d  in  NIRQ  new mask value (1 = line enabled)
ei  in  1  decoded "enable interrupts" instruction
di  in  1  decoded "disable interrupts" instruction
reti  in  1  decoded "return from interrupt" instruction
instr_boundary  in  1  PC updates at the coming edge; interrupts may be taken only then
pc_next  in  PC_W  address the PC would load at that edge
take_int  out  1  select vector into PC mux this cycle
vector  out  PC_W  vector address, valid while take_int=1, else 0
push  out  1  stack push strobe
push_data  out  PC_W  resume address for the stack (= pc_next while push=1, else 0)
pop  out  1  stack pop strobe
pending  out  NIRQ  latched pending requests
in_service  out  NIRQ  one-hot line currently serviced, 0 when idle
gie  out  1  global interrupt enable

Behaviour:
- Reset (asynchronous, active-high; clock clk): state IDLE. gie=0, mask=0, pending=0, in_service=0, synchroniser flops=0. All strobes (take_int, push, pop) = 0; vector=0, push_data=0.
- Per line: 2-flop synchroniser, then rising-edge detect against the previous synchronised value. An edge sets pending[i] regardless of mask or gie.
- Latency: irq_in rises before edge 0 -> sync1 at edge 0, sync2 at edge 1 -> pending=1 after edge 2.
- Eligible set = pending & mask. Winner = lowest index set (line 0 highest priority).
- The FSM has two states, IDLE and ISR:
  - IDLE: take_int=push=1 combinationally iff gie & eligible!=0 & instr_boundary & !di. In that cycle, vector = VEC_BASE + winner*VEC_STRIDE (PC_W-bit, wraps modulo 2^PC_W) and push_data=pc_next. At the edge: state→ISR, pending[winner]←0, in_service←onehot(winner), gie←0.
  - ISR: no interrupt is taken. If reti: pop=1 combinationally; at the edge state→IDLE, in_service←0, gie←1. The stack output is valid one cycle after pop; that is the CPU's concern.
  - reti in IDLE: ignored, no pop.
- gie update priority: reset > entry (clear) > reti (set) > di (clear) > ei (set). ei and di in the same cycle: di wins. ei inside ISR sets gie but has no effect until IDLE, so there is still no nesting.
- Pending set and clear of the same bit in the same cycle: set wins, pending stays 1.
- mask_we applies at the edge. A masked pending bit is held, not discarded.
- pop and push are never asserted in the same cycle.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_ISR), default PC_W, VEC_BASE and VEC_STRIDE constants.
- Sub-module `sync_edge` (2FF synchroniser plus rise detect, 1 bit, async reset), instantiated NIRQ times.
- Priority encoder and FSM live in int_ctrl.

Test Plan:
1. Reset, then ei; pulse irq_in[2] high for 1 clk with instr_boundary=1 and pc_next=10'h045 -> pending[2]=1 after 3 edges; next cycle take_int=push=1, vector=10'h3E8, push_data=10'h045; then in_service=4'b0100, gie=0, pending[2]=0.
2. irq_in[3] and irq_in[1] rise together, mask=4'b1111, gie=1 -> line 1 taken first (vector 10'h3E4); after reti with pop=1 for one cycle, line 3 is taken (vector 10'h3EC).
3. In ISR, raise irq_in[0] and issue ei -> no take_int while in ISR; pending[0]=1 is held; taken at the first boundary after reti.
4. mask=4'b0000, irq_in[1] edge -> pending[1]=1, no take_int; write mask=4'b0010 -> taken at the next boundary.
5. reti in IDLE -> pop=0, no state change. ei and di in the same cycle -> gie=0.
6. Assert reset while in ISR with pending=4'b1010 -> immediately state IDLE, all outputs 0, gie=0. No spurious pop after reset is released.
